// File: rtl/preg_free_list.sv
// preg_free_list: circular free list of physical registers with branch
// checkpoints. Define FREE_LIST_DUP_CHECK_EN to flag double releases.
module preg_free_list #(
  parameter int P_REGS = 64,
  parameter int L_REGS = 32,
  parameter int PORTS  = 2,
  parameter int C_NUM  = 4,
  localparam int DEPTH = P_REGS - L_REGS,
  localparam int PW    = $clog2(P_REGS),
  localparam int CW    = $clog2(C_NUM),
  localparam int FW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PORTS-1:0]    alloc_req,
  output logic                alloc_ready,
  output logic [PORTS*PW-1:0] alloc_preg,
  input  logic [PORTS-1:0]    rel_valid,
  input  logic [PORTS*PW-1:0] rel_preg,
  input  logic                ckpt_take,
  output logic [CW-1:0]       ckpt_id,
  output logic                ckpt_avail,
  input  logic                ckpt_release,
  input  logic                flush_valid,
  input  logic [CW-1:0]       flush_id,
  output logic [FW-1:0]       free_count,
  output logic                err_double_free
);

  localparam int QW = $clog2(2 * DEPTH);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(C_NUM + 1);

  typedef logic [QW-1:0] ptr_t;

  function automatic ptr_t ptr_add(ptr_t p, int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= 32'(2 * DEPTH)) s = s - 32'(2 * DEPTH);
    return ptr_t'(s);
  endfunction

  function automatic ptr_t ptr_sub(ptr_t a, ptr_t b);
    int unsigned s;
    s = 32'(a) + 32'(2 * DEPTH) - 32'(b);
    if (s >= 32'(2 * DEPTH)) s = s - 32'(2 * DEPTH);
    return ptr_t'(s);
  endfunction

  function automatic logic [IW-1:0] slot(ptr_t p);
    int unsigned s;
    s = 32'(p);
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return IW'(s);
  endfunction

  function automatic logic [CW-1:0] ck_inc(logic [CW-1:0] a);
    int unsigned s;
    s = 32'(a) + 1;
    if (s >= 32'(C_NUM)) s = s - 32'(C_NUM);
    return CW'(s);
  endfunction

  function automatic logic [CW-1:0] ck_dist(logic [CW-1:0] a,
                                            logic [CW-1:0] b);
    int unsigned s;
    s = 32'(a) + 32'(C_NUM) - 32'(b);
    if (s >= 32'(C_NUM)) s = s - 32'(C_NUM);
    return CW'(s);
  endfunction

  logic [PW-1:0] fifo [DEPTH];
  ptr_t          head, tail;
  ptr_t          head_alloc, head_nxt, tail_nxt;
  ptr_t          ck_head [C_NUM];
  logic [CW-1:0] ck_old;
  logic [NW-1:0] ck_cnt, ck_cnt_nxt;
  logic [IW-1:0] rel_slot [PORTS];
  int unsigned   n_alloc, n_rel;
  logic          alloc_ok, flush_hit, take_ok, drop_ok;

  // offer FIFO[head+rank] per port; place releases at FIFO[tail+rank]
  always_comb begin
    n_alloc    = 0;
    n_rel      = 0;
    alloc_preg = '0;
    rel_slot   = '{default: '0};
    for (int p = 0; p < PORTS; p++) begin
      alloc_preg[p*PW +: PW] = fifo[slot(ptr_add(head, n_alloc))];
      rel_slot[p] = slot(ptr_add(tail, n_rel));
      if (alloc_req[p]) n_alloc = n_alloc + 1;
      if (rel_valid[p]) n_rel = n_rel + 1;
    end
  end

  // all-or-nothing allocation, flush restore, checkpoint bookkeeping
  always_comb begin
    alloc_ok   = alloc_ready && !flush_valid;
    head_alloc = alloc_ok ? ptr_add(head, n_alloc) : head;
    flush_hit  = flush_valid &&
                 (32'(ck_dist(flush_id, ck_old)) < 32'(ck_cnt));
    take_ok    = ckpt_take && ckpt_avail && !flush_valid;
    drop_ok    = ckpt_release && (ck_cnt != '0) &&
                 !(flush_valid && (flush_id == ck_old));
    head_nxt   = flush_hit ? ck_head[flush_id] : head_alloc;
    tail_nxt   = ptr_add(tail, n_rel);
    ck_cnt_nxt = flush_hit ? NW'(ck_dist(flush_id, ck_old)) : ck_cnt;
    if (take_ok) ck_cnt_nxt = ck_cnt_nxt + NW'(1);
    if (drop_ok) ck_cnt_nxt = ck_cnt_nxt - NW'(1);
  end

  // free list storage, pointers and registered occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= PW'(L_REGS + i);
      head       <= '0;
      tail       <= ptr_t'(DEPTH);
      free_count <= FW'(DEPTH);
    end else begin
      for (int p = 0; p < PORTS; p++)
        if (rel_valid[p]) fifo[rel_slot[p]] <= rel_preg[p*PW +: PW];
      head       <= head_nxt;
      tail       <= tail_nxt;
      free_count <= FW'(ptr_sub(tail_nxt, head_nxt));
    end
  end

  // checkpoint ring: ck_old is the oldest live slot, ckpt_id the next
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_NUM; i++) ck_head[i] <= '0;
      ck_old  <= '0;
      ckpt_id <= '0;
      ck_cnt  <= '0;
    end else begin
      if (take_ok) ck_head[ckpt_id] <= head_alloc;
      if (flush_hit) ckpt_id <= flush_id;
      else if (take_ok) ckpt_id <= ck_inc(ckpt_id);
      if (drop_ok) ck_old <= ck_inc(ck_old);
      ck_cnt <= ck_cnt_nxt;
    end
  end

  assign alloc_ready = 32'(free_count) >= 32'(PORTS);
  assign ckpt_avail  = 32'(ck_cnt) < 32'(C_NUM);

`ifdef FREE_LIST_DUP_CHECK_EN
  localparam logic [P_REGS-1:0] MAP_RST =
    {{DEPTH{1'b1}}, {L_REGS{1'b0}}};

  logic [P_REGS-1:0] free_map, free_map_nxt;
  logic              dup_hit;
  ptr_t              back_n;

  // keep the bitmap equal to the free window; spot repeated releases
  always_comb begin
    free_map_nxt = free_map;
    dup_hit      = 1'b0;
    back_n       = ptr_sub(head, ck_head[flush_id]);
    if (flush_hit)
      for (int j = 0; j < DEPTH; j++)
        if (32'(j) < 32'(back_n))
          free_map_nxt[fifo[slot(ptr_add(ck_head[flush_id], j))]] = 1'b1;
    if (alloc_ok)
      for (int p = 0; p < PORTS; p++)
        if (alloc_req[p]) free_map_nxt[alloc_preg[p*PW +: PW]] = 1'b0;
    for (int p = 0; p < PORTS; p++)
      if (rel_valid[p]) begin
        if (free_map[rel_preg[p*PW +: PW]]) dup_hit = 1'b1;
        for (int q = 0; q < p; q++)
          if (rel_valid[q] &&
              (rel_preg[q*PW +: PW] == rel_preg[p*PW +: PW]))
            dup_hit = 1'b1;
        free_map_nxt[rel_preg[p*PW +: PW]] = 1'b1;
      end
  end

  // sticky error, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_map        <= MAP_RST;
      err_double_free <= 1'b0;
    end else begin
      free_map <= free_map_nxt;
      if (dup_hit) err_double_free <= 1'b1;
    end
  end
`else
  assign err_double_free = 1'b0;
`endif

endmodule

// File: doc/preg_free_list.md
PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 SHALL have parameter P_REGS, default 64, number of physical registers.
REQ-002 SHALL have parameter L_REGS, default 32, number of logical registers; DEPTH = P_REGS-L_REGS, PW = $clog2(P_REGS).
REQ-003 SHALL have parameter PORTS, default 2, allocate/release ports per cycle.
REQ-004 SHALL have parameter C_NUM, default 4, branch checkpoints; CW = $clog2(C_NUM).
REQ-005 SHALL have port clk  in  1  the only clock.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port alloc_req  in  PORTS  per-port allocation request.
REQ-008 SHALL have port alloc_ready  out  1  free_count >= PORTS.
REQ-009 SHALL have port alloc_preg  out  PORTS*PW  preg offered per port.
REQ-010 SHALL have port rel_valid  in  PORTS  per-port release of a committed ppreg.
REQ-011 SHALL have port rel_preg  in  PORTS*PW  preg being released.
REQ-012 SHALL have port ckpt_take  in  1  snapshot head for a new branch.
REQ-013 SHALL have port ckpt_id  out  CW  id the next ckpt_take receives.
REQ-014 SHALL have port ckpt_avail  out  1  a checkpoint slot is free.
REQ-015 SHALL have port ckpt_release  in  1  oldest branch resolved correct; free oldest checkpoint.
REQ-016 SHALL have port flush_valid  in  1  misprediction recovery request.
REQ-017 SHALL have port flush_id  in  CW  checkpoint to restore.
REQ-018 SHALL have port free_count  out  $clog2(DEPTH+1)  registered free entries.
REQ-019 SHALL have port err_double_free  out  1  sticky release-of-free-preg flag.

Function
REQ-020 SHALL store free pregs in a circular FIFO of DEPTH entries; head/tail pointers count modulo 2*DEPTH; free_count = (tail-head) mod 2*DEPTH.
REQ-021 SHALL drive alloc_preg combinationally: k-th set bit of alloc_req (LSB first) gets FIFO[head+k]; unrequested ports show FIFO[head+their rank] as don't-care.
REQ-022 SHALL allocate all-or-nothing: if alloc_ready=0 or flush_valid=1, requests are ignored and head unchanged.
REQ-023 SHALL, on accepted allocation, advance head by popcount(alloc_req) at the clock edge.
REQ-024 SHALL write each valid rel_preg to FIFO[tail+rank] and advance tail by popcount(rel_valid); releases apply in every cycle, including flush cycles.
REQ-025 SHALL treat a release that would exceed DEPTH free entries as a protocol violation (undefined).
REQ-026 SHALL, on ckpt_take with ckpt_avail=1 and no flush, store the post-allocation head in slot ckpt_id and advance ckpt_id mod C_NUM; ignore ckpt_take when ckpt_avail=0.
REQ-027 SHALL allocate checkpoints in circular order; ckpt_avail = live count < C_NUM.
REQ-028 SHALL, on flush_valid with live flush_id, set head to stored head of flush_id and free flush_id and all younger checkpoints; ckpt_id becomes flush_id.
REQ-029 SHALL ignore flush_valid with a non-live flush_id.
REQ-030 SHALL, on ckpt_release, free the oldest live checkpoint; ignored if none live or if flush_id equals the oldest in the same cycle.
REQ-031 SHALL update free_count at the same edge as head/tail, one cycle after the stimulating inputs.

Reset
REQ-032 SHALL on rst: FIFO[i]=L_REGS+i, head=0, tail=DEPTH, free_count=DEPTH, alloc_ready=1, no live checkpoints, ckpt_id=0, ckpt_avail=1, err_double_free=0.
REQ-033 SHALL abandon all in-flight state on rst asserted mid-operation; inputs sampled in that cycle have no effect.

Configuration
REQ-034 SHALL, with FREE_LIST_DUP_CHECK_EN defined, keep a P_REGS-bit free bitmap (reset: bits L_REGS..P_REGS-1 set), set err_double_free the cycle after any release of a preg whose bit is set, hold it until rst.
REQ-035 SHALL, without FREE_LIST_DUP_CHECK_EN, omit the bitmap and tie err_double_free to 0.

Verification (P_REGS=64, L_REGS=32, PORTS=2, C_NUM=4)
REQ-036 SHALL cover: reset -> free_count=32, alloc_preg port0=32 port1=33, alloc_ready=1, ckpt_avail=1.
REQ-037 SHALL cover: alloc_req=2'b11 for 16 cycles -> free_count=0, alloc_ready=0; 17th request -> no change.
REQ-038 SHALL cover: alloc 2'b11 with ckpt_take (count 30, ckpt 0), alloc 2'b11 twice (26), flush_id=0 -> count 30, alloc_preg 34/35.
REQ-039 SHALL cover: empty list, rel_valid=2'b11 pregs 5,7 -> free_count=2 next cycle, alloc_preg 5/7.
REQ-040 SHALL cover: four ckpt_take -> ckpt_avail=0, fifth ignored; ckpt_release -> ckpt_avail=1, ckpt_id=0.
REQ-041 SHALL cover: FREE_LIST_DUP_CHECK_EN defined, release preg 40 after reset -> err_double_free=1 next cycle, stays 1 until rst.
